// File: rtl/hsync_line_tracker.sv
// hsync_line_tracker: receive-side HSync tracker. Synchronizes the incoming
// HSync, measures rise-to-rise period and high width, and locks after
// LOCK_LINES consecutive lines within tolerance. While locked, hPos follows
// the transmitter's horizontal count with a fixed 3-clock lag.
// Optional feature macro: HSYNC_ERRCNT_EN (bad-line counter while locked).
module hsync_line_tracker #(
  parameter int H_TOTAL    = 1600,
  parameter int H_PULSE    = 1408,
  parameter int TOL        = 2,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSync,
  output logic        locked,
  output logic        lineStart,
  output logic [10:0] hPos,
  output logic [10:0] lineLength,
  output logic [10:0] highWidth,
  output logic [7:0]  errCount
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [10:0]        CNT_MAX   = 11'h7FF;
  localparam logic [10:0]        HPOS_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0]        TOTAL_W   = 11'(H_TOTAL);
  localparam logic [10:0]        PULSE_W   = 11'(H_PULSE);
  localparam logic signed [11:0] TOL_S     = 12'(TOL);
  localparam logic [7:0]         GOOD_LAST = 8'(LOCK_LINES - 1);

  logic        hsMeta, hsS, hsD;
  logic        rise, fall;
  logic [10:0] perCnt, highCnt;
  logic [1:0]  state;
  logic [7:0]  goodCnt;
  logic [1:0]  badRun;
  logic        lineValid, timeout;

  // Saturating 11-bit increment shared by both measurement counters.
  function automatic logic [10:0] satInc11(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  // |meas - target| <= TOL, computed in 12-bit signed so nothing wraps.
  function automatic logic withinTol(input logic [10:0] meas, input logic [10:0] target);
    logic signed [11:0] diff;
    diff = $signed({1'b0, meas}) - $signed({1'b0, target});
    return (diff <= TOL_S) && (diff >= -TOL_S);
  endfunction

  assign rise      = hsS & ~hsD;
  assign fall      = ~hsS & hsD;
  // A line is judged in the lineStart cycle, when lineLength holds the fresh period.
  assign lineValid = withinTol(lineLength, TOTAL_W) && withinTol(highWidth, PULSE_W);
  // A rise coinciding with saturation takes priority over the timeout.
  assign timeout   = (perCnt == CNT_MAX) && !rise;
  assign locked    = (state == LOCKED);

  // Two-flop synchronizer plus the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsMeta <= 1'b0;
      hsS    <= 1'b0;
      hsD    <= 1'b0;
    end else begin
      hsMeta <= HSync;
      hsS    <= hsMeta;
      hsD    <= hsS;
    end
  end

  // Period measurement, line-start pulse and regenerated position count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perCnt     <= '0;
      lineLength <= '0;
      lineStart  <= 1'b0;
      hPos       <= '0;
    end else begin
      lineStart <= rise;
      if (rise) begin
        lineLength <= perCnt;
        perCnt     <= 11'd1;
        hPos       <= 11'd1;
      end else begin
        perCnt <= satInc11(perCnt);
        hPos   <= (hPos == HPOS_LAST) ? 11'd0 : hPos + 11'd1;
      end
    end
  end

  // High-width measurement, captured on the synchronized falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      highCnt   <= '0;
      highWidth <= '0;
    end else if (fall) begin
      highWidth <= highCnt;
      highCnt   <= '0;
    end else if (hsS) begin
      highCnt <= satInc11(highCnt);
    end
  end

  // Lock FSM: SEARCH -> VERIFY -> LOCKED, two consecutive bad lines or a timeout unlock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEARCH;
      goodCnt <= '0;
      badRun  <= '0;
    end else if (lineStart) begin
      case (state)
        SEARCH: begin
          state   <= VERIFY;
          goodCnt <= '0;
          badRun  <= '0;
        end
        VERIFY: begin
          if (!lineValid) begin
            goodCnt <= '0;
          end else begin
            goodCnt <= goodCnt + 8'd1;
            if (goodCnt == GOOD_LAST) state <= LOCKED;
          end
        end
        LOCKED: begin
          if (lineValid) begin
            badRun <= '0;
          end else if (badRun == 2'd1) begin
            state   <= SEARCH;
            badRun  <= '0;
            goodCnt <= '0;
          end else begin
            badRun <= badRun + 2'd1;
          end
        end
        default: begin
          state   <= SEARCH;
          goodCnt <= '0;
          badRun  <= '0;
        end
      endcase
    end else if (timeout) begin
      state   <= SEARCH;
      goodCnt <= '0;
      badRun  <= '0;
    end
  end

`ifdef HSYNC_ERRCNT_EN
  // Saturating count of invalid lines seen while locked; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount <= '0;
    end else if (lineStart && locked && !lineValid && errCount != 8'hFF) begin
      errCount <= errCount + 8'd1;
    end
  end
`else
  assign errCount = '0;
`endif

endmodule

// File: tb/tb_hsync_line_tracker.sv
// Directed bench for hsync_line_tracker: lock, tolerance edges, bad lines,
// timeout, asynchronous reset and high-width fault.
module tb_hsync_line_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        HSync = 1'b0;
  logic        locked, lineStart;
  logic [10:0] hPos, lineLength, highWidth;
  logic [7:0]  errCount;

  int checks = 0;
  int fails  = 0;

`ifdef HSYNC_ERRCNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  // Observations recorded by sendLine
  int          lsIdx, lsHits;
  logic        lockedAtLs, lockedAfter;
  logic [10:0] lenAtLs, hPosAtLs, hPosPre, hwEnd;
  logic [7:0]  errAfter;

  hsync_line_tracker dut (
    .clk(clk), .rst_n(rst_n), .HSync(HSync), .locked(locked), .lineStart(lineStart),
    .hPos(hPos), .lineLength(lineLength), .highWidth(highWidth), .errCount(errCount)
  );

  always #5 clk = ~clk;

  // Drives one line (transmitter count 1 at i==0) and records what the DUT shows.
  task automatic sendLine(input int per, input int hi);
    lsIdx  = -1;
    lsHits = 0;
    for (int i = 0; i < per; i++) begin
      @(posedge clk); #1;
      HSync = (i < hi);
      @(negedge clk);
      if (i == 2) hPosPre = hPos;
      if (lineStart) lsHits++;
      if (lineStart && lsIdx < 0) begin
        lsIdx      = i;
        lockedAtLs = locked;
        lenAtLs    = lineLength;
        hPosAtLs   = hPos;
      end
      if (lsIdx >= 0 && i == lsIdx + 1) begin
        lockedAfter = locked;
        errAfter    = errCount;
      end
    end
    hwEnd = highWidth;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    HSync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    HSync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({locked, lineStart, hPos, lineLength, highWidth, errCount} !== 42'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {locked, lineStart, hPos, lineLength, highWidth, errCount});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal_lock();
    for (int k = 1; k <= 6; k++) begin
      sendLine(1600, 1408);
      checks++;
      if (lsIdx !== 3 || lsHits !== 1) begin
        fails++; $display("FAIL nominal_ls_latency line %0d: idx %0d hits %0d expected idx 3 hits 1", k, lsIdx, lsHits);
      end
      checks++;
      if (hPosAtLs !== 11'd1) begin
        fails++; $display("FAIL nominal_hpos_start line %0d: got %0d expected 1", k, hPosAtLs);
      end
      checks++;
      if (hwEnd !== 11'd1408) begin
        fails++; $display("FAIL nominal_highWidth line %0d: got %0d expected 1408", k, hwEnd);
      end
      if (k >= 2) begin
        checks++;
        if (lenAtLs !== 11'd1600) begin
          fails++; $display("FAIL nominal_lineLength line %0d: got %0d expected 1600", k, lenAtLs);
        end
        checks++;
        if (hPosPre !== 11'd0) begin
          fails++; $display("FAIL nominal_hpos_wrap line %0d: got %0d expected 0", k, hPosPre);
        end
      end
      checks++;
      if (lockedAfter !== (k >= 5)) begin
        fails++; $display("FAIL nominal_locked line %0d: got %0b expected %0b", k, lockedAfter, (k >= 5));
      end
      if (k == 5) begin
        checks++;
        if (lockedAtLs !== 1'b0) begin
          fails++; $display("FAIL nominal_locked_early: got %0b expected 0", lockedAtLs);
        end
      end
    end
  endtask

  task automatic test_bad_lines();
    sendLine(1590, 1408);
    sendLine(1600, 1408);
    checks++;
    if (lenAtLs !== 11'd1590) begin
      fails++; $display("FAIL bad_lineLength: got %0d expected 1590", lenAtLs);
    end
    checks++;
    if (lockedAfter !== 1'b1) begin
      fails++; $display("FAIL bad_single_keeps_lock: got %0b expected 1", lockedAfter);
    end
    checks++;
    if (errAfter !== 8'(ERR_EN)) begin
      fails++; $display("FAIL bad_errCount_1: got %0d expected %0d", errAfter, ERR_EN);
    end
    sendLine(1590, 1408);
    sendLine(1590, 1408);
    checks++;
    if (lockedAfter !== 1'b1) begin
      fails++; $display("FAIL bad_first_of_two: got %0b expected 1", lockedAfter);
    end
    sendLine(1600, 1408);
    checks++;
    if (lockedAtLs !== 1'b1 || lockedAfter !== 1'b0) begin
      fails++; $display("FAIL bad_two_unlock: got %0b->%0b expected 1->0", lockedAtLs, lockedAfter);
    end
    checks++;
    if (errAfter !== 8'(3 * ERR_EN)) begin
      fails++; $display("FAIL bad_errCount_3: got %0d expected %0d", errAfter, 3 * ERR_EN);
    end
  endtask

  task automatic test_tolerance();
    doReset();
    for (int k = 1; k <= 5; k++) begin
      sendLine((k == 4) ? 1602 : 1600, 1408);
      if (k >= 4) begin
        checks++;
        if (lockedAfter !== (k == 5)) begin
          fails++; $display("FAIL tol_1602 line %0d: got %0b expected %0b", k, lockedAfter, (k == 5));
        end
      end
    end
    checks++;
    if (lenAtLs !== 11'd1602) begin
      fails++; $display("FAIL tol_1602_len: got %0d expected 1602", lenAtLs);
    end
    doReset();
    for (int k = 1; k <= 9; k++) begin
      sendLine((k == 4) ? 1603 : 1600, 1408);
      if (k == 5) begin
        checks++;
        if (lenAtLs !== 11'd1603) begin
          fails++; $display("FAIL tol_1603_len: got %0d expected 1603", lenAtLs);
        end
      end
      if (k >= 5) begin
        checks++;
        if (lockedAfter !== (k == 9)) begin
          fails++; $display("FAIL tol_1603 line %0d: got %0b expected %0b", k, lockedAfter, (k == 9));
        end
      end
    end
  endtask

  task automatic test_reset_mid_line();
    doReset();
    repeat (5) sendLine(1600, 1408);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      HSync = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (locked !== 1'b1 || hPos !== 11'd17) begin
      fails++; $display("FAIL midline_pre: locked %0b hPos %0d expected 1 and 17", locked, hPos);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({locked, lineStart, hPos, lineLength, highWidth, errCount} !== 42'd0) begin
      fails++; $display("FAIL midline_async_clear: got %h expected 0",
                        {locked, lineStart, hPos, lineLength, highWidth, errCount});
    end
    repeat (3) @(negedge clk);
    HSync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      sendLine(1600, 1408);
      if (k >= 4) begin
        checks++;
        if (lockedAfter !== (k == 5)) begin
          fails++; $display("FAIL midline_relock line %0d: got %0b expected %0b", k, lockedAfter, (k == 5));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    cnt = 1599 - lsIdx;
    for (int j = 0; j < 3000; j++) begin
      @(posedge clk); #1;
      HSync = 1'b0;
      @(negedge clk);
      cnt++;
      if (!locked) break;
    end
    checks++;
    if (cnt !== 2047) begin
      fails++; $display("FAIL timeout_unlock: locked dropped %0d cycles after lineStart, expected 2047", cnt);
    end
  endtask

  task automatic test_high_fault();
    doReset();
    for (int k = 1; k <= 7; k++) begin
      sendLine(1600, 1300);
      checks++;
      if (hwEnd !== 11'd1300) begin
        fails++; $display("FAIL fault_highWidth line %0d: got %0d expected 1300", k, hwEnd);
      end
      checks++;
      if (lockedAfter !== 1'b0) begin
        fails++; $display("FAIL fault_no_lock line %0d: got %0b expected 0", k, lockedAfter);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal_lock();
    test_bad_lines();
    test_tolerance();
    test_reset_mid_line();
    test_timeout();
    test_high_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
